// File: rtl/clkseq_pkg.sv
// Shared types and constants for the clock-lock sequencer.
package clkseq_pkg;

  localparam int CLKSEQ_LOSS_W = 8;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } clkseq_state_t;

  function automatic int unsigned clkseq_max3(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clkseq_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication, resets to 0.
module clkseq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_r;
  (* ASYNC_REG = "TRUE" *) logic sync_r;

  // Metastability settling chain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/clock_lock_sequencer.sv
// PLL reset / lock qualification sequencer in the aclk domain.
// Optional feature macro: CLKSEQ_LOSS_COUNT_EN (lock-loss counter; tied to 0 when undefined).
module clock_lock_sequencer
  import clkseq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic                     aclk_i,
  input  logic                     rst_i,
  input  logic                     locked_i,
  input  logic                     restart_i,
  output logic                     pll_rst_o,
  output logic                     ready_o,
  output logic                     fail_o,
  output logic [2:0]               state_o,
  output logic [CLKSEQ_LOSS_W-1:0] loss_count_o
);

  localparam int unsigned CNT_MAX = clkseq_max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LAST  = 8'(MAX_RETRIES - 1);

  clkseq_state_t    state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       retry_cnt_r;
  logic             locked_s;
  logic             enter_s;
  logic             retry_inc_s;
  logic             retry_clr_s;

  clkseq_sync u_sync (
    .clk (aclk_i),
    .rst (rst_i),
    .d   (locked_i),
    .q   (locked_s)
  );

  // Next-state decode; enter_s marks any state entry so the shared counter restarts
  always_comb begin
    state_nxt_s = state_r;
    enter_s     = 1'b0;
    retry_inc_s = 1'b0;
    retry_clr_s = 1'b0;
    if (restart_i) begin
      state_nxt_s = ST_RESET;
      enter_s     = 1'b1;
      retry_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = ST_RESET;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt_s = ST_STABLE;
            enter_s     = 1'b1;
          end else if (cnt_r == LOCK_LAST) begin
            enter_s = 1'b1;
            if (retry_cnt_r == RETRY_LAST) begin
              state_nxt_s = ST_FAIL;
            end else begin
              state_nxt_s = ST_RESET;
              retry_inc_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // Chatter during qualification is neither a retry nor a loss
          if (!locked_s) begin
            state_nxt_s = ST_RESET;
            enter_s     = 1'b1;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s = ST_READY;
            enter_s     = 1'b1;
            retry_clr_s = 1'b1;
          end else begin
            state_nxt_s = ST_STABLE;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            state_nxt_s = ST_RESET;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_FAIL: begin
          state_nxt_s = ST_FAIL;
        end
        default: begin
          state_nxt_s = ST_RESET;
          enter_s     = 1'b1;
        end
      endcase
    end
  end

  // State, shared counter and retry counter registers
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_r     <= ST_RESET;
      cnt_r       <= {CNT_W{1'b0}};
      retry_cnt_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (enter_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (retry_clr_s) begin
        retry_cnt_r <= 8'd0;
      end else if (retry_inc_s) begin
        retry_cnt_r <= retry_cnt_r + 8'd1;
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
    end
  end

`ifdef CLKSEQ_LOSS_COUNT_EN
  logic [CLKSEQ_LOSS_W-1:0] loss_count_r;
  logic                     loss_inc_s;

  assign loss_inc_s = (state_r == ST_READY) && !locked_s && !restart_i;

  // Saturating count of lock losses seen while READY
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      loss_count_r <= {CLKSEQ_LOSS_W{1'b0}};
    end else if (loss_inc_s && (loss_count_r != {CLKSEQ_LOSS_W{1'b1}})) begin
      loss_count_r <= loss_count_r + CLKSEQ_LOSS_W'(1);
    end else begin
      loss_count_r <= loss_count_r;
    end
  end

  assign loss_count_o = loss_count_r;
`else
  assign loss_count_o = {CLKSEQ_LOSS_W{1'b0}};
`endif

  // Outputs decode only the state register, so they are glitch-free
  assign pll_rst_o = (state_r == ST_RESET) || (state_r == ST_FAIL);
  assign ready_o   = (state_r == ST_READY);
  assign fail_o    = (state_r == ST_FAIL);
  assign state_o   = state_r;

endmodule

// File: doc/clock_lock_sequencer.md
# clock_lock_sequencer

Controller on the initiating side of the clock-generation PLL handshake: drives the PLL reset and consumes the combined PLL lock indication. Sequences PLL reset, waits for lock with timeout and bounded retry, qualifies lock stability, then asserts a clean `ready_o` for downstream reset release. Re-runs the sequence on lock loss. Sits in the `aclk` domain beside the clock generator, ahead of all ifclk/memclk reset logic.

## Interface

- `RST_CYCLES`, default 16: PLL reset pulse width in aclk cycles, ≥2.
- `LOCK_TIMEOUT`, default 65536: cycles allowed in WAIT_LOCK before a retry, ≥2.
- `STABLE_CYCLES`, default 1024: consecutive locked cycles required before READY, ≥2.
- `MAX_RETRIES`, default 7: consecutive timeouts before FAIL, 1..255.

- `aclk_i` in 1: sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `locked_i` in 1: PLL lock, asynchronous to `aclk_i`.
- `restart_i` in 1: single-cycle request to force a full relock.
- `pll_rst_o` out 1: PLL reset, to the generator's reset input.
- `ready_o` out 1: clocks qualified stable.
- `fail_o` out 1: retries exhausted.
- `state_o` out 3: current state encoding.
- `loss_count_o` out 8: saturating count of lock losses from READY.

## Operation

- `locked_i` passes through a 2-flop synchronizer. Only the synchronized `locked_s` is used.
- One shared counter `cnt`, cleared on every state entry.
- `retry_cnt` counts consecutive WAIT_LOCK timeouts.
- States (package enum): RESET=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4.
  - RESET: `pll_rst_o`=1. At `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `locked_s`, go to STABLE. Otherwise at `cnt`==LOCK_TIMEOUT-1:
    - if `retry_cnt`==MAX_RETRIES-1, go to FAIL;
    - else increment `retry_cnt` and go to RESET.
  - STABLE: if `!locked_s`, go to RESET (chatter; neither retry nor loss counted). At `cnt`==STABLE_CYCLES-1 with `locked_s`, go to READY and clear `retry_cnt`.
  - READY: `ready_o`=1. If `!locked_s`, go to RESET and increment `loss_count` (saturates at 255).
  - FAIL: `pll_rst_o`=1, `fail_o`=1. Held until `restart_i` or `rst_i`.
- `restart_i` in any state: go to RESET and clear `retry_cnt`. Not counted as a loss. Lower priority than `rst_i`, higher priority than every other transition.
- Outputs decode the state register only; they are glitch-free and registered-equivalent.

## Timing

- During and after `rst_i`: state=RESET, `cnt`=0, `retry_cnt`=0, `loss_count_o`=0, synchronizer flops=0, `pll_rst_o`=1, `ready_o`=0, `fail_o`=0, `state_o`=0.
- `rst_i` mid-sequence aborts immediately. The next cycle is cycle 0 of RESET.
- `pll_rst_o` high for exactly RST_CYCLES cycles per RESET visit.
- `locked_i` rise to STABLE entry: 3 cycles (2 sync + 1 state update).
- READY is reached exactly STABLE_CYCLES cycles after STABLE entry.
- `locked_i` fall in READY to `ready_o`=0 and `pll_rst_o`=1: exactly 3 cycles.
- `locked_s` deasserting on the same cycle that STABLE completes: go to RESET, not READY.
- `restart_i` on the same cycle as a timeout: restart wins, `retry_cnt`=0.
- `loss_count` at 255 with another loss: holds 255.

## Configuration

- `CLKSEQ_LOSS_COUNT_EN` defined: `loss_count` register is implemented as above.
- Undefined: the register is removed and `loss_count_o` is tied to 0. All other behaviour is identical.

## Structure

- `clkseq_pkg`: `clkseq_state_t` enum (3-bit, values above) and `CLKSEQ_LOSS_W`=8.
- `cnt` width is $clog2 of the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- One sub-module: `clkseq_sync`, a 2-flop synchronizer with ASYNC_REG attributes and reset value 0.

## Test plan

Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3.

1. Release `rst_i`, raise `locked_i` 10 cycles later -> `pll_rst_o` high 4 cycles, `ready_o` rises exactly 11 cycles after `locked_i` rises, `state_o`=3.
2. `locked_i` held 0 -> three RESET/WAIT_LOCK passes, then `state_o`=4, `fail_o`=1, `pll_rst_o`=1. A `restart_i` pulse -> `fail_o`=0 next cycle, 4-cycle RESET.
3. In READY, drop `locked_i` for 1 cycle -> `ready_o` falls exactly 3 cycles later, `loss_count_o`=1, full resequence.
4. Toggle `locked_i` low at STABLE cycle 5 -> return to RESET, `loss_count_o` unchanged, retry count unchanged.
5. Force 256 lock losses from READY -> `loss_count_o`=255. With `CLKSEQ_LOSS_COUNT_EN` undefined -> `loss_count_o`=0 throughout.
6. Assert `rst_i` and `restart_i` together in WAIT_LOCK -> all outputs at reset values next cycle, `loss_count_o`=0.
